// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer for the RV64I core with run/step control.
// Define CORE_SEQ_CTRL_WATCHDOG_EN to build the memory-wait watchdog (error codes 3/4).
module core_seq_ctrl #(
  parameter int unsigned WD_LIMIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic             ifetch_req_o,
  input  logic             ifetch_ack_i,
  input  logic             ifetch_err_i,
  output logic             inst_latch_o,
  input  logic             decode_err_i,
  input  logic             ecall_i,
  input  logic             ebreak_i,
  input  logic             need_mem_i,
  output logic             dmem_req_o,
  input  logic             dmem_ack_i,
  input  logic             dmem_err_i,
  output logic             pc_we_o,
  output logic             rf_we_o,
  output logic [2:0]       state_o,
  output logic [2:0]       err_code_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERROR  = 3'd6
  } state_e;

  localparam logic [2:0] ErrFetch   = 3'd0;
  localparam logic [2:0] ErrDecode  = 3'd1;
  localparam logic [2:0] ErrMem     = 3'd2;
  localparam logic [2:0] ErrIllegal = 3'd7;

  if (WD_LIMIT < 2 || WD_LIMIT > 255) begin : g_wdLimitCheck
    $error("core_seq_ctrl: WD_LIMIT must be within 2..255");
  end

  state_e           state_q, state_d;
  logic [2:0]       errCode_q, errCode_d;
  logic [CNT_W-1:0] retired_q, retired_d;

`ifdef CORE_SEQ_CTRL_WATCHDOG_EN
  localparam logic [7:0] ErrFetchWd = 8'd3;
  localparam logic [7:0] ErrMemWd   = 8'd4;
  localparam logic [7:0] WdLast     = 8'(WD_LIMIT - 1);

  logic [7:0] waitCnt_q, waitCnt_d;
  logic       wdExpired;

  assign wdExpired = (waitCnt_q == WdLast);

  // Counter restarts whenever the state changes, so each request starts from zero.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_d != state_q) begin
      waitCnt_d = '0;
    end else if (state_q == FETCH || state_q == MEM) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      waitCnt_q <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    errCode_d    = errCode_q;
    retired_d    = retired_q;
    ifetch_req_o = 1'b0;
    inst_latch_o = 1'b0;
    dmem_req_o   = 1'b0;
    pc_we_o      = 1'b0;
    rf_we_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_i || step_i) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        ifetch_req_o = 1'b1;
        if (ifetch_ack_i) begin
          if (ifetch_err_i) begin
            state_d   = ERROR;
            errCode_d = ErrFetch;
          end else begin
            inst_latch_o = 1'b1;
            state_d      = DECODE;
          end
`ifdef CORE_SEQ_CTRL_WATCHDOG_EN
        end else if (wdExpired) begin
          state_d   = ERROR;
          errCode_d = ErrFetchWd[2:0];
`endif
        end
      end

      // Illegal instruction outranks ECALL/EBREAK, which outrank memory access.
      DECODE: begin
        if (decode_err_i) begin
          state_d   = ERROR;
          errCode_d = ErrDecode;
        end else if (ebreak_i || ecall_i) begin
          state_d = HALT;
        end else if (need_mem_i) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        dmem_req_o = 1'b1;
        if (dmem_ack_i) begin
          if (dmem_err_i) begin
            state_d   = ERROR;
            errCode_d = ErrMem;
          end else begin
            state_d = WB;
          end
`ifdef CORE_SEQ_CTRL_WATCHDOG_EN
        end else if (wdExpired) begin
          state_d   = ERROR;
          errCode_d = ErrMemWd[2:0];
`endif
        end
      end

      WB: begin
        pc_we_o   = 1'b1;
        rf_we_o   = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = run_i ? FETCH : IDLE;
      end

      HALT: begin
        state_d = HALT;
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d   = ERROR;
        errCode_d = ErrIllegal;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      errCode_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      errCode_q <= errCode_d;
      retired_q <= retired_d;
    end
  end

  assign state_o    = state_q;
  assign err_code_o = (state_q == ERROR) ? errCode_q : 3'd0;
  assign halted_o   = (state_q == HALT) || (state_q == ERROR);
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed self-checking bench for core_seq_ctrl; inputs change and outputs are
// sampled 1-2 time units after each rising edge.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst, run, step;
  logic        ifetchAck, ifetchErr, decodeErr, ecall, ebreak, needMem;
  logic        dmemAck, dmemErr;
  logic        ifetchReq, instLatch, dmemReq, pcWe, rfWe, halted;
  logic [2:0]  stateO, errCode;
  logic [31:0] retired;

  int testsRun    = 0;
  int testsFailed = 0;

  core_seq_ctrl #(.WD_LIMIT(16), .CNT_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .step_i       (step),
    .ifetch_req_o (ifetchReq),
    .ifetch_ack_i (ifetchAck),
    .ifetch_err_i (ifetchErr),
    .inst_latch_o (instLatch),
    .decode_err_i (decodeErr),
    .ecall_i      (ecall),
    .ebreak_i     (ebreak),
    .need_mem_i   (needMem),
    .dmem_req_o   (dmemReq),
    .dmem_ack_i   (dmemAck),
    .dmem_err_i   (dmemErr),
    .pc_we_o      (pcWe),
    .rf_we_o      (rfWe),
    .state_o      (stateO),
    .err_code_o   (errCode),
    .halted_o     (halted),
    .retired_o    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    run = 0; step = 0; ifetchAck = 0; ifetchErr = 0; decodeErr = 0;
    ecall = 0; ebreak = 0; needMem = 0; dmemAck = 0; dmemErr = 0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    cycle();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    // Busy inputs during reset must not leak into the post-reset state.
    clearInputs();
    rst = 1; run = 1; ifetchAck = 1; dmemAck = 1;
    cycle();
    cycle();
    testsRun++; if (stateO !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d want 0", stateO); end
    testsRun++; if (ifetchReq !== 1'b0 || dmemReq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_req: got if=%0b dm=%0b want 0", ifetchReq, dmemReq); end
    testsRun++; if (pcWe !== 1'b0 || rfWe !== 1'b0 || instLatch !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pulses: got pc=%0b rf=%0b lat=%0b want 0", pcWe, rfWe, instLatch); end
    testsRun++; if (errCode !== 3'd0 || halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_status: got err=%0d halt=%0b want 0", errCode, halted); end
    testsRun++; if (retired !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
    rst = 0;
    clearInputs();
    #1;
  endtask

  task automatic test_run_zero_wait();
    logic [2:0] expState [13];
    expState = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
    doReset();
    run = 1; ifetchAck = 1;
    #1;
    for (int c = 0; c < 13; c++) begin
      testsRun++; if (stateO !== expState[c]) begin testsFailed++; $display("[TB] FAIL run_state[%0d]: got %0d want %0d", c, stateO, expState[c]); end
      testsRun++; if (pcWe !== (expState[c] == 3'd4)) begin testsFailed++; $display("[TB] FAIL run_pcwe[%0d]: got %0b want %0b", c, pcWe, expState[c] == 3'd4); end
      testsRun++; if (instLatch !== (expState[c] == 3'd1)) begin testsFailed++; $display("[TB] FAIL run_latch[%0d]: got %0b want %0b", c, instLatch, expState[c] == 3'd1); end
      cycle();
    end
    testsRun++; if (retired !== 32'd4) begin testsFailed++; $display("[TB] FAIL run_retired: got %0d want 4", retired); end
    // Dropping run while in FETCH: the instruction finishes, then IDLE.
    run = 0;
    cycle();
    cycle();
    testsRun++; if (pcWe !== 1'b1 || rfWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL stop_wb: got pc=%0b rf=%0b want 1", pcWe, rfWe); end
    cycle();
    testsRun++; if (stateO !== 3'd0 || retired !== 32'd5) begin testsFailed++; $display("[TB] FAIL stop_idle: got state=%0d ret=%0d want 0/5", stateO, retired); end
    cycle();
    testsRun++; if (stateO !== 3'd0 || ifetchReq !== 1'b0 || retired !== 32'd5) begin testsFailed++; $display("[TB] FAIL stop_hold: got state=%0d req=%0b ret=%0d want 0/0/5", stateO, ifetchReq, retired); end
  endtask

  task automatic test_step_load();
    doReset();
    step = 1;
    #1;
    testsRun++; if (ifetchReq !== 1'b0) begin testsFailed++; $display("[TB] FAIL step_idle_req: got %0b want 0", ifetchReq); end
    cycle();
    step = 0;
    testsRun++; if (stateO !== 3'd1 || ifetchReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_fetch: got state=%0d req=%0b want 1/1", stateO, ifetchReq); end
    ifetchAck = 1;
    #1;
    testsRun++; if (instLatch !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_latch: got %0b want 1", instLatch); end
    cycle();
    ifetchAck = 0; needMem = 1;
    #1;
    testsRun++; if (stateO !== 3'd2) begin testsFailed++; $display("[TB] FAIL step_decode: got %0d want 2", stateO); end
    cycle();
    needMem = 0;
    // Three MEM cycles without ack; a step pulse arrives in the middle one.
    for (int k = 0; k < 3; k++) begin
      if (k == 1) step = 1;
      #1;
      testsRun++; if (stateO !== 3'd3 || dmemReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_mem_wait[%0d]: got state=%0d req=%0b want 3/1", k, stateO, dmemReq); end
      cycle();
      step = 0;
    end
    dmemAck = 1;
    cycle();
    dmemAck = 0;
    #1;
    testsRun++; if (stateO !== 3'd4 || pcWe !== 1'b1 || rfWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL step_wb: got state=%0d pc=%0b rf=%0b want 4/1/1", stateO, pcWe, rfWe); end
    cycle();
    testsRun++; if (stateO !== 3'd0 || retired !== 32'd1) begin testsFailed++; $display("[TB] FAIL step_done: got state=%0d ret=%0d want 0/1", stateO, retired); end
    cycle();
    cycle();
    testsRun++; if (stateO !== 3'd0 || pcWe !== 1'b0 || retired !== 32'd1) begin testsFailed++; $display("[TB] FAIL step_not_queued: got state=%0d pc=%0b ret=%0d want 0/0/1", stateO, pcWe, retired); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] expState [9];
    expState = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    doReset();
    run = 1; ifetchAck = 1; needMem = 1; dmemAck = 1;
    #1;
    for (int c = 0; c < 9; c++) begin
      testsRun++; if (stateO !== expState[c]) begin testsFailed++; $display("[TB] FAIL b2b_state[%0d]: got %0d want %0d", c, stateO, expState[c]); end
      testsRun++; if (dmemReq !== (expState[c] == 3'd3)) begin testsFailed++; $display("[TB] FAIL b2b_dreq[%0d]: got %0b want %0b", c, dmemReq, expState[c] == 3'd3); end
      cycle();
    end
    testsRun++; if (stateO !== 3'd1 || retired !== 32'd2) begin testsFailed++; $display("[TB] FAIL b2b_retired: got state=%0d ret=%0d want 1/2", stateO, retired); end
  endtask

  task automatic test_ebreak_halt();
    doReset();
    run = 1; ifetchAck = 1;
    cycle();
    cycle();
    ebreak = 1;
    #1;
    testsRun++; if (stateO !== 3'd2) begin testsFailed++; $display("[TB] FAIL halt_decode: got %0d want 2", stateO); end
    cycle();
    ebreak = 0;
    testsRun++; if (stateO !== 3'd5 || halted !== 1'b1 || errCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL halt_state: got state=%0d halt=%0b err=%0d want 5/1/0", stateO, halted, errCode); end
    testsRun++; if (retired !== 32'd0) begin testsFailed++; $display("[TB] FAIL halt_retired: got %0d want 0", retired); end
    step = 1; dmemAck = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      testsRun++; if (stateO !== 3'd5 || ifetchReq !== 1'b0 || pcWe !== 1'b0 || dmemReq !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_sticky[%0d]: got state=%0d req=%0b pc=%0b dreq=%0b want 5/0/0/0", k, stateO, ifetchReq, pcWe, dmemReq); end
    end
    doReset();
    testsRun++; if (stateO !== 3'd0 || halted !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_cleared: got state=%0d halt=%0b want 0/0", stateO, halted); end
  endtask

  task automatic test_errors();
    doReset();
    run = 1;
    cycle();
    ifetchAck = 1; ifetchErr = 1;
    #1;
    testsRun++; if (instLatch !== 1'b0 || ifetchReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL ferr_latch: got lat=%0b req=%0b want 0/1", instLatch, ifetchReq); end
    cycle();
    testsRun++; if (stateO !== 3'd6 || errCode !== 3'd0 || halted !== 1'b1) begin testsFailed++; $display("[TB] FAIL ferr_state: got state=%0d err=%0d halt=%0b want 6/0/1", stateO, errCode, halted); end
    ifetchErr = 0;
    cycle();
    testsRun++; if (instLatch !== 1'b0 || stateO !== 3'd6) begin testsFailed++; $display("[TB] FAIL ferr_sticky: got lat=%0b state=%0d want 0/6", instLatch, stateO); end

    // Illegal instruction outranks a simultaneous ECALL.
    doReset();
    run = 1; ifetchAck = 1;
    cycle();
    cycle();
    decodeErr = 1; ecall = 1;
    cycle();
    decodeErr = 0; ecall = 0;
    testsRun++; if (stateO !== 3'd6 || errCode !== 3'd1 || retired !== 32'd0) begin testsFailed++; $display("[TB] FAIL derr_state: got state=%0d err=%0d ret=%0d want 6/1/0", stateO, errCode, retired); end

    doReset();
    run = 1; ifetchAck = 1; needMem = 1;
    cycle();
    cycle();
    cycle();
    dmemAck = 1; dmemErr = 1;
    cycle();
    testsRun++; if (stateO !== 3'd6 || errCode !== 3'd2 || pcWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL merr_state: got state=%0d err=%0d pc=%0b want 6/2/0", stateO, errCode, pcWe); end
    doReset();
    testsRun++; if (errCode !== 3'd0 || stateO !== 3'd0) begin testsFailed++; $display("[TB] FAIL merr_cleared: got state=%0d err=%0d want 0/0", stateO, errCode); end
  endtask

  task automatic test_watchdog();
    doReset();
    step = 1;
    cycle();
    step = 0; ifetchAck = 1;
    cycle();
    ifetchAck = 0; needMem = 1;
    cycle();
    needMem = 0;
`ifdef CORE_SEQ_CTRL_WATCHDOG_EN
    for (int k = 1; k <= 16; k++) begin
      testsRun++; if (stateO !== 3'd3) begin testsFailed++; $display("[TB] FAIL wd_mem_wait[%0d]: got %0d want 3", k, stateO); end
      cycle();
    end
    testsRun++; if (stateO !== 3'd6 || errCode !== 3'd4) begin testsFailed++; $display("[TB] FAIL wd_expire: got state=%0d err=%0d want 6/4", stateO, errCode); end
`else
    for (int k = 0; k < 100; k++) cycle();
    testsRun++; if (stateO !== 3'd3 || dmemReq !== 1'b1 || errCode !== 3'd0) begin testsFailed++; $display("[TB] FAIL no_wd_wait: got state=%0d req=%0b err=%0d want 3/1/0", stateO, dmemReq, errCode); end
`endif
  endtask

  task automatic test_reset_mid();
    doReset();
    step = 1;
    cycle();
    step = 0; ifetchAck = 1;
    cycle();
    ifetchAck = 0;
    cycle();
    cycle();
    testsRun++; if (stateO !== 3'd0 || retired !== 32'd1) begin testsFailed++; $display("[TB] FAIL mid_first: got state=%0d ret=%0d want 0/1", stateO, retired); end
    step = 1;
    cycle();
    step = 0; ifetchAck = 1;
    cycle();
    ifetchAck = 0; needMem = 1;
    cycle();
    needMem = 0;
    testsRun++; if (stateO !== 3'd3 || dmemReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_in_mem: got state=%0d req=%0b want 3/1", stateO, dmemReq); end
    // Ack coincides with reset; it must not complete the access.
    rst = 1; dmemAck = 1;
    cycle();
    testsRun++; if (dmemReq !== 1'b0 || stateO !== 3'd0 || retired !== 32'd0) begin testsFailed++; $display("[TB] FAIL mid_reset: got req=%0b state=%0d ret=%0d want 0/0/0", dmemReq, stateO, retired); end
    rst = 0; dmemAck = 0;
    cycle();
    testsRun++; if (stateO !== 3'd0 || pcWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL mid_after: got state=%0d pc=%0b want 0/0", stateO, pcWe); end
  endtask

  initial begin
    clearInputs();
    rst = 1;
    test_reset();
    test_run_zero_wait();
    test_step_load();
    test_back_to_back();
    test_ebreak_halt();
    test_errors();
    test_watchdog();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
